olivia_retire_monitor: RTL and testbench

- Synthesizable, parametrised retire monitor for the Olivia core; sits beside the datapath and observes one retired instruction per cycle.
- Classifies each instruction and recomputes the expected ALU result or address, flagging mismatches.
- Keeps per-class event counters and records a circular trace of {pc, instruction, mismatch} for post-mortem readout.
- Replaces per-cycle self-checking that otherwise exists only in simulation.

---
 rtl/olivia_pkg.sv | 25 ++
 rtl/olivia_retire_monitor_if.sv | 53 +++++
 rtl/olivia_instr_check.sv | 62 ++++++
 rtl/olivia_retire_monitor.sv | 162 ++++++++++++++++
 tb/tb_olivia_retire_monitor.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/olivia_pkg.sv
// Shared opcode constants and instruction classes for the Olivia retire monitor.
package olivia_pkg;

    // 11-bit R/D-format opcodes in instr[31:21]
    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;

    // Branch opcodes: CBZ in instr[31:24], B in instr[31:26]
    localparam logic [7:0]  OpCbz  = 8'hB4;
    localparam logic [5:0]  OpB    = 6'b000101;

    typedef enum logic [2:0] {
        ClsRtype,
        ClsMem,
        ClsCbz,
        ClsB,
        ClsNop,
        ClsUnknown
    } instr_class_e;

endpackage

// File: rtl/olivia_retire_monitor_if.sv
// Retire and trace-readout bundle between the core side and the monitor.
interface olivia_retire_monitor_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic            retire_valid;
    logic [XLEN-1:0] ret_pc;
    logic [31:0]     ret_instr;
    logic [XLEN-1:0] ret_op_a;
    logic [XLEN-1:0] ret_op_b;
    logic [XLEN-1:0] ret_imm;
    logic [XLEN-1:0] ret_result;
    logic            clear;
    logic            rd_en;
    logic [AW-1:0]   rd_idx;

    logic             rd_valid;
    logic             rd_empty;
    logic [XLEN-1:0]  rd_pc;
    logic [31:0]      rd_instr;
    logic             rd_mismatch;
    logic [AW:0]      fill;
    logic             wrapped;
    logic             frozen;
    logic             err_flag;
    logic [XLEN-1:0]  first_err_pc;
    logic [CNT_W-1:0] cnt_retired;
    logic [CNT_W-1:0] cnt_rtype;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_unknown;
    logic [CNT_W-1:0] cnt_mismatch;

    modport master (
        output retire_valid, ret_pc, ret_instr, ret_op_a, ret_op_b, ret_imm, ret_result,
        output clear, rd_en, rd_idx,
        input  rd_valid, rd_empty, rd_pc, rd_instr, rd_mismatch, fill, wrapped, frozen,
        input  err_flag, first_err_pc, cnt_retired, cnt_rtype, cnt_mem, cnt_branch,
        input  cnt_unknown, cnt_mismatch
    );

    modport slave (
        input  retire_valid, ret_pc, ret_instr, ret_op_a, ret_op_b, ret_imm, ret_result,
        input  clear, rd_en, rd_idx,
        output rd_valid, rd_empty, rd_pc, rd_instr, rd_mismatch, fill, wrapped, frozen,
        output err_flag, first_err_pc, cnt_retired, cnt_rtype, cnt_mem, cnt_branch,
        output cnt_unknown, cnt_mismatch
    );

endinterface

// File: rtl/olivia_instr_check.sv
// Combinational classifier and result recomputation for one retired instruction.
module olivia_instr_check
    import olivia_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_result,
    output instr_class_e    o_class,
    output logic            o_checked,
    output logic            o_mismatch
);

    logic [XLEN-1:0] w_expected;

    // Decode in priority order; only R-type and memory ops carry an expected value
    always_comb begin
        o_class    = ClsUnknown;
        o_checked  = 1'b0;
        w_expected = '0;
        if (i_instr[31:24] == OpCbz) begin
            o_class = ClsCbz;
        end else if (i_instr[31:26] == OpB) begin
            o_class = ClsB;
        end else begin
            case (i_instr[31:21])
                OpAdd: begin
                    o_class    = ClsRtype;
                    o_checked  = 1'b1;
                    w_expected = i_op_a + i_op_b;
                end
                OpSub: begin
                    o_class    = ClsRtype;
                    o_checked  = 1'b1;
                    w_expected = i_op_a - i_op_b;
                end
                OpAnd: begin
                    o_class    = ClsRtype;
                    o_checked  = 1'b1;
                    w_expected = i_op_a & i_op_b;
                end
                OpOrr: begin
                    o_class    = ClsRtype;
                    o_checked  = 1'b1;
                    w_expected = i_op_a | i_op_b;
                end
                OpLdur, OpStur: begin
                    o_class    = ClsMem;
                    o_checked  = 1'b1;
                    w_expected = i_op_a + i_imm;
                end
                default: o_class = (i_instr == 32'd0) ? ClsNop : ClsUnknown;
            endcase
        end
    end

    assign o_mismatch = o_checked && (i_result != w_expected);

endmodule

// File: rtl/olivia_retire_monitor.sv
// Retire monitor: event counters, circular trace buffer, error capture and trace readout.
module olivia_retire_monitor
    import olivia_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned FREEZE_ON_ERR = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    olivia_retire_monitor_if.slave mon
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    instr_class_e w_class;
    logic         w_checked;
    logic         w_mismatch;

    olivia_instr_check #(
        .XLEN(XLEN)
    ) u_check (
        .i_instr   (mon.ret_instr),
        .i_op_a    (mon.ret_op_a),
        .i_op_b    (mon.ret_op_b),
        .i_imm     (mon.ret_imm),
        .i_result  (mon.ret_result),
        .o_class   (w_class),
        .o_checked (w_checked),
        .o_mismatch(w_mismatch)
    );

    logic             r_rd_valid, r_rd_empty, r_rd_mismatch;
    logic [XLEN-1:0]  r_rd_pc;
    logic [31:0]      r_rd_instr;
    logic [AW-1:0]    r_wr_ptr;
    logic [FW-1:0]    r_fill;
    logic             r_wrapped, r_frozen, r_err;
    logic [XLEN-1:0]  r_first_err_pc;
    logic [CNT_W-1:0] r_cnt [6];

    logic [XLEN-1:0]  r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic             r_mem_mm    [DEPTH];

    // A retire coinciding with clear is dropped entirely
    logic          w_retire, w_write, w_err;
    logic [5:0]    w_inc;
    logic [AW-1:0] w_rd_phys;
    logic          w_rd_empty;

    assign w_retire = mon.retire_valid && !mon.clear;
    assign w_write  = w_retire && !r_frozen;
    assign w_err    = w_retire && w_checked && w_mismatch;

    // Per-counter increment strobes: retired, rtype, mem, branch, unknown, mismatch
    always_comb begin
        w_inc    = '0;
        w_inc[0] = w_retire;
        w_inc[1] = w_retire && (w_class == ClsRtype);
        w_inc[2] = w_retire && (w_class == ClsMem);
        w_inc[3] = w_retire && ((w_class == ClsCbz) || (w_class == ClsB));
        w_inc[4] = w_retire && (w_class == ClsUnknown);
        w_inc[5] = w_err;
    end

    // Saturating event counters; they keep counting while the trace is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
        end else if (mon.clear) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Trace pointers, fill level, wrap/freeze state and first-error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_fill         <= '0;
            r_wrapped      <= 1'b0;
            r_frozen       <= 1'b0;
            r_err          <= 1'b0;
            r_first_err_pc <= '0;
        end else if (mon.clear) begin
            r_wr_ptr       <= '0;
            r_fill         <= '0;
            r_wrapped      <= 1'b0;
            r_frozen       <= 1'b0;
            r_err          <= 1'b0;
            r_first_err_pc <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_fill == FW'(DEPTH)) r_wrapped <= 1'b1;
                else                      r_fill    <= r_fill + FW'(1);
            end
            if (w_err && !r_err) begin
                r_err          <= 1'b1;
                r_first_err_pc <= mon.ret_pc;
            end
            // The failing entry is still written this edge, so it ends up newest
            if (w_err && (FREEZE_ON_ERR != 0)) r_frozen <= 1'b1;
        end
    end

    // Trace storage; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_pc[r_wr_ptr]    <= mon.ret_pc;
            r_mem_instr[r_wr_ptr] <= mon.ret_instr;
            r_mem_mm[r_wr_ptr]    <= w_mismatch;
        end
    end

    // rd_idx is relative to the oldest entry, which sits at wr_ptr once wrapped
    assign w_rd_phys  = r_wrapped ? (r_wr_ptr + mon.rd_idx) : mon.rd_idx;
    assign w_rd_empty = ({1'b0, mon.rd_idx} >= r_fill);

    // Registered readout; sees pre-write and pre-clear state of the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid    <= 1'b0;
            r_rd_empty    <= 1'b0;
            r_rd_pc       <= '0;
            r_rd_instr    <= '0;
            r_rd_mismatch <= 1'b0;
        end else begin
            r_rd_valid <= mon.rd_en;
            if (mon.rd_en) begin
                r_rd_empty    <= w_rd_empty;
                r_rd_pc       <= w_rd_empty ? '0    : r_mem_pc[w_rd_phys];
                r_rd_instr    <= w_rd_empty ? '0    : r_mem_instr[w_rd_phys];
                r_rd_mismatch <= w_rd_empty ? 1'b0  : r_mem_mm[w_rd_phys];
            end
        end
    end

    assign mon.rd_valid     = r_rd_valid;
    assign mon.rd_empty     = r_rd_empty;
    assign mon.rd_pc        = r_rd_pc;
    assign mon.rd_instr     = r_rd_instr;
    assign mon.rd_mismatch  = r_rd_mismatch;
    assign mon.fill         = r_fill;
    assign mon.wrapped      = r_wrapped;
    assign mon.frozen       = r_frozen;
    assign mon.err_flag     = r_err;
    assign mon.first_err_pc = r_first_err_pc;
    assign mon.cnt_retired  = r_cnt[0];
    assign mon.cnt_rtype    = r_cnt[1];
    assign mon.cnt_mem      = r_cnt[2];
    assign mon.cnt_branch   = r_cnt[3];
    assign mon.cnt_unknown  = r_cnt[4];
    assign mon.cnt_mismatch = r_cnt[5];

endmodule

// File: tb/tb_olivia_retire_monitor.sv
// Bench for olivia_retire_monitor: two instances (freeze on / off) share one stimulus
// stream and are checked every cycle against a queue-based model.
module tb_olivia_retire_monitor;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire_valid, clear, rd_en;
    logic [63:0] ret_pc, op_a, op_b, imm, result;
    logic [31:0] ret_instr;
    logic [3:0]  rd_idx;
    bit          cmp_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    olivia_retire_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus_f ();
    olivia_retire_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus_n ();

    assign bus_f.retire_valid = retire_valid;
    assign bus_f.ret_pc       = ret_pc;
    assign bus_f.ret_instr    = ret_instr;
    assign bus_f.ret_op_a     = op_a;
    assign bus_f.ret_op_b     = op_b;
    assign bus_f.ret_imm      = imm;
    assign bus_f.ret_result   = result;
    assign bus_f.clear        = clear;
    assign bus_f.rd_en        = rd_en;
    assign bus_f.rd_idx       = rd_idx;
    assign bus_n.retire_valid = retire_valid;
    assign bus_n.ret_pc       = ret_pc;
    assign bus_n.ret_instr    = ret_instr;
    assign bus_n.ret_op_a     = op_a;
    assign bus_n.ret_op_b     = op_b;
    assign bus_n.ret_imm      = imm;
    assign bus_n.ret_result   = result;
    assign bus_n.clear        = clear;
    assign bus_n.rd_en        = rd_en;
    assign bus_n.rd_idx       = rd_idx;

    olivia_retire_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .FREEZE_ON_ERR(1)
    ) dut_f (
        .clk  (clk),
        .rst_n(rst_n),
        .mon  (bus_f.slave)
    );

    olivia_retire_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .FREEZE_ON_ERR(0)
    ) dut_n (
        .clk  (clk),
        .rst_n(rst_n),
        .mon  (bus_n.slave)
    );

    // ---------------- model ----------------
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mm;
    } ent_t;

    ent_t        q_f[$];
    ent_t        q_n[$];
    logic [31:0] m_cnt [2][6];   // retired, rtype, mem, branch, unknown, mismatch
    logic        m_wrapped [2];
    logic        m_frozen [2];
    logic        m_err [2];
    logic [63:0] m_fep [2];
    logic        m_rdv [2];
    logic        m_rde [2];
    ent_t        m_rd [2];

    // cls: 0 rtype, 1 mem, 2 branch, 3 nop, 4 unknown
    function automatic void classify(input logic [31:0] ins, input logic [63:0] a, b, im,
                                     output int cls, output bit chk, output logic [63:0] ex);
        logic [10:0] op;
        op  = ins[31:21];
        chk = 1'b0;
        ex  = 64'd0;
        if (ins[31:24] == 8'hB4 || ins[31:26] == 6'h05) cls = 2;
        else if (op == 11'h458) begin cls = 0; chk = 1'b1; ex = a + b; end
        else if (op == 11'h658) begin cls = 0; chk = 1'b1; ex = a - b; end
        else if (op == 11'h450) begin cls = 0; chk = 1'b1; ex = a & b; end
        else if (op == 11'h550) begin cls = 0; chk = 1'b1; ex = a | b; end
        else if (op == 11'h7C2 || op == 11'h7C0) begin cls = 1; chk = 1'b1; ex = a + im; end
        else if (ins == 32'd0) cls = 3;
        else cls = 4;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) m_cnt[k][i] = 32'd0;
            m_wrapped[k] = 1'b0;
            m_frozen[k]  = 1'b0;
            m_err[k]     = 1'b0;
            m_fep[k]     = 64'd0;
        end
        q_f.delete();
        q_n.delete();
    endtask

    task automatic push(input int k, input ent_t e);
        if (k == 0) begin
            if (q_f.size() == DEPTH) begin m_wrapped[0] = 1'b1; void'(q_f.pop_front()); end
            q_f.push_back(e);
        end else begin
            if (q_n.size() == DEPTH) begin m_wrapped[1] = 1'b1; void'(q_n.pop_front()); end
            q_n.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int          cls, sz;
        bit          chk, mm;
        logic [63:0] ex;
        ent_t        e;
        if (!rst_n) begin
            model_clear();
            for (int k = 0; k < 2; k++) begin
                m_rdv[k] = 1'b0;
                m_rde[k] = 1'b0;
                m_rd[k]  = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_rdv[k] = rd_en;
                if (rd_en) begin
                    sz = (k == 0) ? q_f.size() : q_n.size();
                    if (int'(rd_idx) >= sz) begin
                        m_rde[k] = 1'b1;
                        m_rd[k]  = '0;
                    end else begin
                        m_rde[k] = 1'b0;
                        m_rd[k]  = (k == 0) ? q_f[rd_idx] : q_n[rd_idx];
                    end
                end
            end
            if (clear) begin
                model_clear();
            end else if (retire_valid) begin
                classify(ret_instr, op_a, op_b, imm, cls, chk, ex);
                mm = chk && (result != ex);
                e  = '{pc: ret_pc, instr: ret_instr, mm: mm};
                for (int k = 0; k < 2; k++) begin
                    if (m_cnt[k][0] != 32'hFFFF_FFFF) m_cnt[k][0] = m_cnt[k][0] + 1;
                    if (cls == 0 && m_cnt[k][1] != 32'hFFFF_FFFF) m_cnt[k][1] = m_cnt[k][1] + 1;
                    if (cls == 1 && m_cnt[k][2] != 32'hFFFF_FFFF) m_cnt[k][2] = m_cnt[k][2] + 1;
                    if (cls == 2 && m_cnt[k][3] != 32'hFFFF_FFFF) m_cnt[k][3] = m_cnt[k][3] + 1;
                    if (cls == 4 && m_cnt[k][4] != 32'hFFFF_FFFF) m_cnt[k][4] = m_cnt[k][4] + 1;
                    if (mm && m_cnt[k][5] != 32'hFFFF_FFFF) m_cnt[k][5] = m_cnt[k][5] + 1;
                    if (!m_frozen[k]) push(k, e);
                    if (mm && !m_err[k]) begin m_err[k] = 1'b1; m_fep[k] = ret_pc; end
                    if (mm && k == 0) m_frozen[k] = 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic cmp_inst(input int k, input logic rdv, rde, input logic [63:0] rpc,
                            input logic [31:0] rins, input logic rmm, input logic [4:0] fl,
                            input logic wr, fr, er, input logic [63:0] fep,
                            input logic [31:0] c0, c1, c2, c3, c4, c5);
        string s;
        int    sz;
        s  = (k == 0) ? "frz" : "nofrz";
        sz = (k == 0) ? q_f.size() : q_n.size();
        chk({s, ".rd_valid"}, 64'(rdv), 64'(m_rdv[k]));
        if (m_rdv[k]) begin
            chk({s, ".rd_empty"}, 64'(rde), 64'(m_rde[k]));
            chk({s, ".rd_pc"}, rpc, m_rd[k].pc);
            chk({s, ".rd_instr"}, 64'(rins), 64'(m_rd[k].instr));
            chk({s, ".rd_mismatch"}, 64'(rmm), 64'(m_rd[k].mm));
        end
        chk({s, ".fill"}, 64'(fl), 64'(sz));
        chk({s, ".wrapped"}, 64'(wr), 64'(m_wrapped[k]));
        chk({s, ".frozen"}, 64'(fr), 64'(m_frozen[k]));
        chk({s, ".err_flag"}, 64'(er), 64'(m_err[k]));
        chk({s, ".first_err_pc"}, fep, m_fep[k]);
        chk({s, ".cnt_retired"}, 64'(c0), 64'(m_cnt[k][0]));
        chk({s, ".cnt_rtype"}, 64'(c1), 64'(m_cnt[k][1]));
        chk({s, ".cnt_mem"}, 64'(c2), 64'(m_cnt[k][2]));
        chk({s, ".cnt_branch"}, 64'(c3), 64'(m_cnt[k][3]));
        chk({s, ".cnt_unknown"}, 64'(c4), 64'(m_cnt[k][4]));
        chk({s, ".cnt_mismatch"}, 64'(c5), 64'(m_cnt[k][5]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, bus_f.rd_valid, bus_f.rd_empty, bus_f.rd_pc, bus_f.rd_instr,
                     bus_f.rd_mismatch, bus_f.fill, bus_f.wrapped, bus_f.frozen,
                     bus_f.err_flag, bus_f.first_err_pc, bus_f.cnt_retired, bus_f.cnt_rtype,
                     bus_f.cnt_mem, bus_f.cnt_branch, bus_f.cnt_unknown, bus_f.cnt_mismatch);
            cmp_inst(1, bus_n.rd_valid, bus_n.rd_empty, bus_n.rd_pc, bus_n.rd_instr,
                     bus_n.rd_mismatch, bus_n.fill, bus_n.wrapped, bus_n.frozen,
                     bus_n.err_flag, bus_n.first_err_pc, bus_n.cnt_retired, bus_n.cnt_rtype,
                     bus_n.cnt_mem, bus_n.cnt_branch, bus_n.cnt_unknown, bus_n.cnt_mismatch);
        end
    end

    // ---------------- stimulus ----------------
    task automatic retire(input logic [63:0] pc, input logic [31:0] ins,
                          input logic [63:0] a, b, im, res);
        ret_pc       = pc;
        ret_instr    = ins;
        op_a         = a;
        op_b         = b;
        imm          = im;
        result       = res;
        retire_valid = 1'b1;
        @(negedge clk);
        retire_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        @(negedge clk);
        rd_en  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        retire_valid = 1'b0;
        clear        = 1'b0;
        rd_en        = 1'b0;
        rd_idx       = 4'd0;
        ret_pc       = 64'd0;
        ret_instr    = 32'd0;
        op_a         = 64'd0;
        op_b         = 64'd0;
        imm          = 64'd0;
        result       = 64'd0;
        repeat (2) @(negedge clk);
        chk("reset.fill", 64'(bus_f.fill), 64'd0);
        chk("reset.cnt_retired", 64'(bus_f.cnt_retired), 64'd0);
        chk("reset.rd_valid", 64'(bus_f.rd_valid), 64'd0);
        chk("reset.err_flag", 64'(bus_n.err_flag), 64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // ADD 5+7=12
        retire(64'h100, 32'h8B020021, 64'd5, 64'd7, 64'd0, 64'd12);
        chk("add.cnt_rtype", 64'(bus_f.cnt_rtype), 64'd1);
        chk("add.cnt_mismatch", 64'(bus_f.cnt_mismatch), 64'd0);
        rd(4'd0);
        chk("add.rd_pc", bus_f.rd_pc, 64'h100);
        chk("add.rd_instr", 64'(bus_f.rd_instr), 64'h8B020021);
        chk("add.rd_mismatch", 64'(bus_f.rd_mismatch), 64'd0);

        // SUB 3-5 wraps, then wrong SUB result, then one more retire
        retire(64'h104, 32'hCB020021, 64'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("subwrap.err_flag", 64'(bus_f.err_flag), 64'd0);
        retire(64'h108, 32'hCB020021, 64'd3, 64'd5, 64'd0, 64'd0);
        chk("subbad.err_flag", 64'(bus_f.err_flag), 64'd1);
        chk("subbad.first_err_pc", bus_f.first_err_pc, 64'h108);
        chk("subbad.frozen", 64'(bus_f.frozen), 64'd1);
        chk("subbad.nofrz_frozen", 64'(bus_n.frozen), 64'd0);
        retire(64'h10C, 32'hAA020021, 64'hF0, 64'h0F, 64'd0, 64'hFF);
        chk("frozen.fill", 64'(bus_f.fill), 64'd3);
        chk("frozen.nofrz_fill", 64'(bus_n.fill), 64'd4);
        chk("frozen.cnt_retired", 64'(bus_f.cnt_retired), 64'd4);
        rd(4'd2);
        chk("frozen.rd_pc", bus_f.rd_pc, 64'h108);
        chk("frozen.rd_mismatch", 64'(bus_f.rd_mismatch), 64'd1);

        // clear together with a retire and a read
        clear        = 1'b1;
        rd_en        = 1'b1;
        rd_idx       = 4'd0;
        ret_pc       = 64'h300;
        ret_instr    = 32'h8B020021;
        op_a         = 64'd1;
        op_b         = 64'd1;
        result       = 64'd2;
        retire_valid = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        rd_en        = 1'b0;
        retire_valid = 1'b0;
        chk("clear.rd_pc_preclear", bus_f.rd_pc, 64'h100);
        chk("clear.cnt_retired", 64'(bus_f.cnt_retired), 64'd0);
        chk("clear.fill", 64'(bus_f.fill), 64'd0);
        rd(4'd0);
        chk("clear.rd_empty", 64'(bus_f.rd_empty), 64'd1);
        chk("clear.rd_pc_zero", bus_f.rd_pc, 64'd0);

        // 20 retires into a 16-deep buffer
        for (int i = 0; i < 20; i++) begin
            retire(64'(i * 4), 32'h8B020021, 64'(i * 4), 64'd0, 64'd0, 64'(i * 4));
        end
        chk("wrap.fill", 64'(bus_f.fill), 64'd16);
        chk("wrap.wrapped", 64'(bus_f.wrapped), 64'd1);
        rd(4'd0);
        chk("wrap.rd_oldest", bus_f.rd_pc, 64'd16);
        rd(4'd15);
        chk("wrap.rd_newest", bus_f.rd_pc, 64'd76);

        // unchecked classes, then memory ops
        do_clear();
        retire(64'h400, 32'hB4000040, 64'd1, 64'd2, 64'd3, 64'd99);
        retire(64'h404, 32'h14000010, 64'd1, 64'd2, 64'd3, 64'd99);
        retire(64'h408, 32'h00000000, 64'd1, 64'd2, 64'd3, 64'd99);
        retire(64'h40C, 32'hD503201F, 64'd1, 64'd2, 64'd3, 64'd99);
        chk("cls.cnt_branch", 64'(bus_f.cnt_branch), 64'd2);
        chk("cls.cnt_unknown", 64'(bus_f.cnt_unknown), 64'd1);
        chk("cls.cnt_retired", 64'(bus_f.cnt_retired), 64'd4);
        chk("cls.err_flag", 64'(bus_f.err_flag), 64'd0);
        retire(64'h410, 32'hF8410020, 64'h1000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFF8);
        retire(64'h414, 32'hF8010020, 64'h1000, 64'd0, 64'd8, 64'hFF8);
        chk("mem.cnt_mem", 64'(bus_f.cnt_mem), 64'd2);
        chk("mem.cnt_mismatch", 64'(bus_f.cnt_mismatch), 64'd1);
        chk("mem.first_err_pc", bus_f.first_err_pc, 64'h414);

        // async reset mid-cycle with fill=5 and a read in flight
        do_clear();
        for (int i = 0; i < 5; i++) begin
            retire(64'h500 + 64'(i * 4), 32'h8A020021, 64'hFF, 64'h0F, 64'd0, 64'h0F);
        end
        rd_en  = 1'b1;
        rd_idx = 4'd0;
        @(posedge clk);
        #2;
        chk("areset.pre_rd_valid", 64'(bus_f.rd_valid), 64'd1);
        chk("areset.pre_fill", 64'(bus_f.fill), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("areset.rd_valid", 64'(bus_f.rd_valid), 64'd0);
        chk("areset.fill", 64'(bus_f.fill), 64'd0);
        chk("areset.cnt_retired", 64'(bus_n.cnt_retired), 64'd0);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // recording continues past a mismatch when freeze is disabled
        retire(64'h600, 32'h8B020021, 64'd1, 64'd1, 64'd0, 64'd3);
        retire(64'h604, 32'h8B020021, 64'd1, 64'd1, 64'd0, 64'd2);
        retire(64'h608, 32'h8B020021, 64'd1, 64'd1, 64'd0, 64'd2);
        chk("nofrz.err_flag", 64'(bus_n.err_flag), 64'd1);
        chk("nofrz.fill", 64'(bus_n.fill), 64'd3);
        chk("nofrz.frozen", 64'(bus_n.frozen), 64'd0);
        chk("frz.fill", 64'(bus_f.fill), 64'd1);
        rd(4'd2);
        chk("nofrz.rd_pc", bus_n.rd_pc, 64'h608);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
